// File: rtl/mips_dmem_responder.sv
// Data-memory responder: word RAM plus an I/O page with GPIO and a compare timer.
// Optional macro TIMER_PRESCALE_EN adds a 16-bit timer prescaler at offset 0x018.
module mips_dmem_responder #(
    parameter int          DEPTH_WORDS = 64,
    parameter logic [31:0] IO_BASE     = 32'hFFFF0000,
    parameter int          GPIO_W      = 16
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              memwrite,
    input  logic [31:0]       memaddr,
    input  logic [31:0]       memwritedata,
    output logic [31:0]       memreaddata,
    input  logic [GPIO_W-1:0] gpio_in,
    output logic [GPIO_W-1:0] gpio_out,
    output logic              irq,
    output logic              misalign_err
);

    localparam int          AW        = (DEPTH_WORDS > 1) ? $clog2(DEPTH_WORDS) : 1;
    localparam logic [31:0] RAM_LIMIT = 32'(DEPTH_WORDS * 4);

    localparam logic [11:0] OFF_GPIO_OUT = 12'h000;
    localparam logic [11:0] OFF_GPIO_IN  = 12'h004;
    localparam logic [11:0] OFF_CNT      = 12'h008;
    localparam logic [11:0] OFF_CMP      = 12'h00C;
    localparam logic [11:0] OFF_CTRL     = 12'h010;
    localparam logic [11:0] OFF_STATUS   = 12'h014;
    localparam logic [11:0] OFF_PRESCALE = 12'h018;

    logic [31:0]       mem [DEPTH_WORDS];
    logic [GPIO_W-1:0] sync1, sync2;
    logic [31:0]       timer_cnt, timer_cmp;
    logic [2:0]        ctrl;
    logic              match_flag;

    logic              aligned, in_ram, in_io, wr;
    logic [11:0]       io_off;
    logic [AW-1:0]     ram_idx;
    logic              wr_io, wr_cnt, wr_ctrl, wr_status;
    logic              step, match;

    assign aligned   = (memaddr[1:0] == 2'b00);
    assign in_ram    = (memaddr < RAM_LIMIT);
    assign in_io     = (memaddr[31:12] == IO_BASE[31:12]);
    assign io_off    = {memaddr[11:2], 2'b00};
    assign ram_idx   = memaddr[AW+1:2];
    assign wr        = memwrite & aligned;
    assign wr_io     = wr & in_io;
    assign wr_cnt    = wr_io & (io_off == OFF_CNT);
    assign wr_ctrl   = wr_io & (io_off == OFF_CTRL);
    assign wr_status = wr_io & (io_off == OFF_STATUS);

`ifdef TIMER_PRESCALE_EN
    logic [15:0] prescale, psc_cnt;
    logic        wr_psc;
    assign wr_psc = wr_io & (io_off == OFF_PRESCALE);
    assign step   = ctrl[0] & (psc_cnt == prescale);
`else
    assign step   = ctrl[0];
`endif

    // A CPU write to the counter suppresses that cycle's compare entirely.
    assign match = step & ~wr_cnt & (timer_cnt == timer_cmp);
    assign irq   = match_flag & ctrl[2];

    always_comb begin
        memreaddata = '0;
        if (in_ram) begin
            memreaddata = mem[ram_idx];
        end else if (in_io) begin
            case (io_off)
                OFF_GPIO_OUT: memreaddata = 32'(gpio_out);
                OFF_GPIO_IN:  memreaddata = 32'(sync2);
                OFF_CNT:      memreaddata = timer_cnt;
                OFF_CMP:      memreaddata = timer_cmp;
                OFF_CTRL:     memreaddata = {29'd0, ctrl};
                OFF_STATUS:   memreaddata = {31'd0, match_flag};
`ifdef TIMER_PRESCALE_EN
                OFF_PRESCALE: memreaddata = {16'd0, prescale};
`endif
                default:      memreaddata = '0;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (!reset && wr && in_ram) begin
            mem[ram_idx] <= memwritedata;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            sync1        <= '0;
            sync2        <= '0;
            gpio_out     <= '0;
            timer_cnt    <= '0;
            timer_cmp    <= 32'hFFFFFFFF;
            ctrl         <= '0;
            match_flag   <= 1'b0;
            misalign_err <= 1'b0;
`ifdef TIMER_PRESCALE_EN
            prescale     <= '0;
            psc_cnt      <= '0;
`endif
        end else begin
            sync1 <= gpio_in;
            sync2 <= sync1;

            // Misaligned reads only count when they land in a mapped region.
            if (!aligned && (memwrite || in_ram || in_io)) begin
                misalign_err <= 1'b1;
            end

            if (wr_io && io_off == OFF_GPIO_OUT) gpio_out  <= memwritedata[GPIO_W-1:0];
            if (wr_io && io_off == OFF_CMP)      timer_cmp <= memwritedata;
            if (wr_ctrl)                         ctrl      <= memwritedata[2:0];

            if (wr_cnt) begin
                timer_cnt <= memwritedata;
            end else if (step) begin
                timer_cnt <= (match && ctrl[1]) ? 32'd0 : timer_cnt + 32'd1;
            end

            if (match) begin
                match_flag <= 1'b1;
            end else if (wr_status && memwritedata[0]) begin
                match_flag <= 1'b0;
            end

`ifdef TIMER_PRESCALE_EN
            if (wr_psc) prescale <= memwritedata[15:0];
            if (wr_ctrl || wr_psc) begin
                psc_cnt <= '0;
            end else if (ctrl[0]) begin
                psc_cnt <= (psc_cnt == prescale) ? 16'd0 : psc_cnt + 16'd1;
            end
`endif
        end
    end

endmodule
